// File: rtl/mul_hilo.sv
// Sequential 32x32 unsigned multiplier with HI/LO result registers.
// Plain multiply takes 32 shift-add cycles; multiply-accumulate adds one more cycle.
module mul_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mad,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  sel,
  output logic [31:0] dout,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StAcc, StDone} state_e;

  state_e      state_q;
  logic [63:0] mcand_q;
  logic [63:0] prod_q;
  logic [31:0] mplier_q;
  logic [4:0]  cnt_q;
  logic        mad_q;
  logic [63:0] prod_d;

  // Partial product for the multiplier bit currently at position 0.
  always_comb begin
    prod_d = prod_q + (mplier_q[0] ? mcand_q : 64'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      mcand_q  <= 64'd0;
      prod_q   <= 64'd0;
      mplier_q <= 32'd0;
      cnt_q    <= 5'd0;
      mad_q    <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            mcand_q  <= {32'd0, a};
            mplier_q <= b;
            mad_q    <= mad;
            prod_q   <= 64'd0;
            cnt_q    <= 5'd0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            if (mad_q) begin
              state_q <= StAcc;
            end else begin
              {hi, lo} <= prod_d;
              busy     <= 1'b0;
              done     <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StAcc: begin
          // Carry out of bit 63 is dropped.
          {hi, lo} <= {hi, lo} + prod_q;
          busy     <= 1'b0;
          done     <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    dout = 32'd0;
    case (sel)
      2'b01:   dout = hi;
      2'b10:   dout = lo;
      default: dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mul_hilo.sv
// Self-checking bench for mul_hilo: scoreboard of expected {HI,LO} and latency per operation.
module tb_mul_hilo;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mad;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  sel;
  logic [31:0] dout;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [63:0] val;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model;
  int          n_checks;
  int          n_fail;

  mul_hilo dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mad   (mad),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .dout  (dout),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation, optionally poke start with junk operands poke_at edges after the
  // start edge, then wait for done and check against the scoreboard head.
  task automatic run_op(input logic m, input logic [31:0] x, input logic [31:0] y,
                        input int poke_at);
    exp_t        e;
    logic [63:0] prev;
    logic        changed;
    int          n;
    @(negedge clk);
    start = 1'b1;
    mad   = m;
    a     = x;
    b     = y;
    e.val = m ? model + ({32'd0, x} * {32'd0, y}) : ({32'd0, x} * {32'd0, y});
    e.lat = m ? 33 : 32;
    model = e.val;
    sb.push_back(e);
    prev    = {hi, lo};
    changed = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    mad   = ~m;
    a     = $urandom;
    b     = $urandom;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (n == poke_at) begin
        start = 1'b1;
        a     = 32'h0000_1234;
        b     = 32'h0000_5678;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) break;
      if ({hi, lo} !== prev) changed = 1'b1;
      if (n >= 100) break;
    end
    start = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (n !== e.lat) begin
      n_fail++;
      $display("FAIL done_latency: got %0d edges want %0d", n, e.lat);
    end
    n_checks++;
    if ({hi, lo} !== e.val) begin
      n_fail++;
      $display("FAIL hilo_result: got %h want %h", {hi, lo}, e.val);
    end
    n_checks++;
    if (changed !== 1'b0) begin
      n_fail++;
      $display("FAIL hilo_stable_while_busy: got changed=%b want 0", changed);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_at_done: got %b want 0", busy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got %b want 0", done);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    mad   = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    sel   = 2'b01;
    model = 64'd0;
    #13;
    n_checks++;
    if ({hi, lo, busy, done, dout} !== 98'd0) begin
      n_fail++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dout=%h want all 0",
               hi, lo, busy, done, dout);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_mul();
    run_op(1'b0, 32'd3, 32'd5, -1);
    sel = 2'b10;
    #1;
    n_checks++;
    if (dout !== 32'd15) begin
      n_fail++;
      $display("FAIL basic_dout_lo: got %h want %h", dout, 32'd15);
    end
    sel = 2'b01;
    #1;
    n_checks++;
    if (dout !== 32'd0) begin
      n_fail++;
      $display("FAIL basic_dout_hi: got %h want %h", dout, 32'd0);
    end
    run_op(1'b0, 32'd0, 32'd12345, -1);
  endtask

  task automatic test_max();
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++;
      $display("FAIL max_operands: got %h want FFFFFFFE00000001", {hi, lo});
    end
  endtask

  task automatic test_accumulate();
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, -1);
    run_op(1'b1, 32'd2, 32'd3, -1);
    n_checks++;
    if ({hi, lo} !== 64'h0000_0001_0000_0006) begin
      n_fail++;
      $display("FAIL mad_small: got %h want 0000000100000006", {hi, lo});
    end
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFC_0000_0002) begin
      n_fail++;
      $display("FAIL mad_wrap: got %h want FFFFFFFC00000002", {hi, lo});
    end
  endtask

  task automatic test_start_busy();
    int extra;
    run_op(1'b0, 32'd7, 32'd9, 10);
    n_checks++;
    if (lo !== 32'd63) begin
      n_fail++;
      $display("FAIL start_busy_lo: got %0d want 63", lo);
    end
    extra = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL start_busy_extra_done: got %0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int busies;
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, -1);
    run_op(1'b1, 32'd2, 32'd3, -1);
    @(negedge clk);
    start = 1'b1;
    mad   = 1'b0;
    a     = 32'd11;
    b     = 32'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model = 64'd0;
    n_checks++;
    if ({busy, hi, lo} !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got busy=%b hi=%h lo=%h want 0", busy, hi, lo);
    end
    @(negedge clk);
    rst    = 1'b1;
    dones  = 0;
    busies = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busies++;
    end
    n_checks++;
    if (dones !== 0 || busies !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got done=%0d busy=%0d cycles want 0", dones, busies);
    end
    run_op(1'b0, 32'd4, 32'd4, -1);
  endtask

  task automatic test_readout();
    logic [1:0]  sels[4];
    logic [31:0] want[4];
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    sels[0] = 2'b11; want[0] = 32'd0;
    sels[1] = 2'b00; want[1] = 32'd0;
    sels[2] = 2'b01; want[2] = 32'hFFFF_FFFE;
    sels[3] = 2'b10; want[3] = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin
      sel = sels[i];
      #1;
      n_checks++;
      if (dout !== want[i]) begin
        n_fail++;
        $display("FAIL readout_sel%b: got %h want %h", sels[i], dout, want[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_mul();
    test_max();
    test_accumulate();
    test_start_busy();
    test_reset_mid();
    test_readout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_hilo.md
MUL_HILO -- requirements
Module: mul_hilo

Interface
REQ-001 The module SHALL provide one clock and an asynchronous, active-low reset; ports: clk input 1 (rising-edge clock); rst input 1 (active-low asynchronous reset).
REQ-002 The module SHALL provide: start input 1; pulse requesting a multiply, sampled only in IDLE.
REQ-003 The module SHALL provide: mad input 1; sampled with start; 1 = multiply-accumulate (funct 1), 0 = plain multiply (funct 25).
REQ-004 The module SHALL provide: a input 32 and b input 32; unsigned operands, sampled with start.
REQ-005 The module SHALL provide: sel input 2; readout select from ALU control; 01 = HI, 10 = LO, 00 and 11 = none.
REQ-006 The module SHALL provide: dout output 32; the selected HI or LO value.
REQ-007 The module SHALL provide: busy output 1; high in RUN and ACC.
REQ-008 The module SHALL provide: done output 1; one-cycle completion pulse.
REQ-009 The module SHALL provide: hi output 32 and lo output 32; direct views of the HI and LO registers.

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, RUN, ACC and DONE.
REQ-011 In IDLE with start=1, the clock edge SHALL latch a, b and mad, clear the 64-bit product accumulator and the 5-bit bit counter, and enter RUN.
REQ-012 RUN SHALL be an unsigned shift-add: each edge processes one multiplier bit, LSB first, for exactly 32 edges (counter 0..31).
REQ-013 On the 32nd RUN edge with mad=0, the module SHALL write {HI,LO} = product and enter DONE; done is visible 32 edges after the start edge.
REQ-014 On the 32nd RUN edge with mad=1, the module SHALL enter ACC; the ACC edge SHALL write {HI,LO} = {HI,LO} + product, modulo 2^64 (carry out of bit 63 discarded), and enter DONE; done is visible 33 edges after the start edge.
REQ-015 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE unconditionally.
REQ-016 start SHALL be ignored in RUN, ACC and DONE; such a pulse is not queued.
REQ-017 Operand or mad changes after the start edge SHALL NOT affect the operation in progress.
REQ-018 HI and LO SHALL change only on the final RUN edge (mul) or the ACC edge (mad); reads during busy SHALL return the previous values.
REQ-019 dout SHALL be combinational from sel and HI/LO: 01 gives HI, 10 gives LO, 00 and 11 give 32'h0.
REQ-020 A zero operand SHALL still take the full 32 RUN cycles; there is no early termination.

Reset
REQ-021 rst=0 SHALL immediately, without waiting for clk, force IDLE, HI=LO=0, accumulator=0, counter=0, busy=0 and done=0.
REQ-022 Reset asserted during RUN or ACC SHALL abort the operation: no HI/LO write and no done pulse.
REQ-023 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-024 The bench SHALL cover basic multiply: mul 3×5 -> done 32 edges after start; HI=0, LO=15; sel=10 gives dout=15; sel=01 gives dout=0.
REQ-025 The bench SHALL cover maximum operands: mul FFFFFFFF×FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
REQ-026 The bench SHALL cover accumulate and accumulator wrap: mul 00010000×00010000 then mad 2×3 -> HI=1, LO=6, with done 33 edges after the mad start. Then mul FFFFFFFF×FFFFFFFF followed by mad FFFFFFFF×FFFFFFFF -> HI=FFFFFFFC, LO=00000002.
REQ-027 The bench SHALL cover start while busy: after mul 7×9, change a and b and pulse start 10 edges into RUN -> exactly one done; LO=63.
REQ-028 The bench SHALL cover reset mid-operation: HI=1, LO=6 preset; start mul, then assert rst 15 edges into RUN -> busy=0 and HI=LO=0 before the next clk edge; no done follows.
REQ-029 The bench SHALL cover readout select: HI=FFFFFFFE, LO=00000001 with sel=11 -> dout=0, and with sel=00 -> dout=0.
